// File: rtl/sm_spi_pkg.sv
// Shared opcodes, FSM state encoding and data-source select for the SPI flash responder.
package sm_spi_pkg;

  localparam logic [7:0] OP_READ     = 8'h03;
  localparam logic [7:0] OP_RDID     = 8'h9F;
  localparam logic [7:0] OP_RDSR     = 8'h05;
  localparam logic [7:0] STATUS_BYTE = 8'h00;

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, IGNORE} state_e;
  typedef enum logic [1:0] {SRC_MEM, SRC_ID, SRC_STATUS} src_e;

  // Byte idx of the ID sequence: three ID bytes MSB-first, then zeros.
  function automatic logic [7:0] id_byte(input logic [23:0] id, input logic [23:0] idx);
    case (idx)
      24'd0:   return id[23:16];
      24'd1:   return id[15:8];
      24'd2:   return id[7:0];
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/sm_sync_edge.sv
// Two-flop synchronizer for an asynchronous level, with one-cycle rise/fall pulses.
module sm_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta, r_sync, r_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
      r_prev <= RST_VAL;
    end else begin
      // NOTE: non-blocking assignments keep this a true three-stage shift chain.
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_rise =  r_sync & ~r_prev;
  assign o_fall = ~r_sync &  r_prev;

endmodule

// File: rtl/spi_flash_responder.sv
// SPI mode-0 flash-read responder: READ (0x03), JEDEC ID (0x9F) and status (0x05)
// served from a loadable byte memory, with all SPI inputs oversampled on clk_50.
module spi_flash_responder
  import sm_spi_pkg::*;
#(
  parameter int          DEPTH    = 1024,
  parameter logic [23:0] JEDEC_ID = 24'hEF4018
) (
  input  logic                     clk_50,
  input  logic                     rst,
  input  logic                     spi_cs,
  input  logic                     spi_sck,
  input  logic                     spi_si,
  output logic                     spi_so,
  input  logic                     mem_we,
  input  logic [$clog2(DEPTH)-1:0] mem_waddr,
  input  logic [7:0]               mem_wdata,
  output logic                     busy,
  output logic                     cmd_err
);

  localparam int AW = $clog2(DEPTH);

  logic w_cs_rise, w_cs_fall, w_sck_rise, w_sck_fall;
  logic r_si_meta, r_si_sync;

  sm_sync_edge #(.RST_VAL(1'b1)) u_cs_sync (
    .clk(clk_50), .rst(rst), .i_async(spi_cs), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
  );

  sm_sync_edge #(.RST_VAL(1'b0)) u_sck_sync (
    .clk(clk_50), .rst(rst), .i_async(spi_sck), .o_rise(w_sck_rise), .o_fall(w_sck_fall)
  );

  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) begin
      r_si_meta <= 1'b0;
      r_si_sync <= 1'b0;
    end else begin
      r_si_meta <= spi_si;
      r_si_sync <= r_si_meta;
    end
  end

  // Synchronized cs level rebuilt from its edge pulses; busy follows it without lag.
  logic r_cs_low;
  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst)            r_cs_low <= 1'b0;
    else if (w_cs_fall) r_cs_low <= 1'b1;
    else if (w_cs_rise) r_cs_low <= 1'b0;
  end
  assign busy = (r_cs_low | w_cs_fall) & ~w_cs_rise;

  // A cs fall is only a new command once cs has been seen high for three cycles, so the
  // synchronizer flushing its reset value while cs is held low cannot start a transaction.
  logic [1:0] r_cs_hi_cnt;
  logic       w_cs_armed;
  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst)                       r_cs_hi_cnt <= 2'd0;
    else if (busy)                 r_cs_hi_cnt <= 2'd0;
    else if (r_cs_hi_cnt != 2'd3)  r_cs_hi_cnt <= r_cs_hi_cnt + 2'd1;
  end
  assign w_cs_armed = (r_cs_hi_cnt == 2'd3);

  state_e      r_state;
  src_e        r_src;
  logic [4:0]  r_bit_cnt;
  logic [22:0] r_shift;
  logic [23:0] r_addr;
  logic [7:0]  r_tx;
  logic        r_so;
  logic        r_cmd_err;

  // NOTE: no reset on the array or its read register, so it maps onto block RAM and rst leaves contents intact.
  logic [7:0] r_mem [DEPTH];
  logic [7:0] r_rd_data;
  always_ff @(posedge clk_50) begin
    if (mem_we) r_mem[mem_waddr] <= mem_wdata;
    r_rd_data <= r_mem[r_addr[AW-1:0]];
  end

  logic [23:0] w_shift_in;
  logic [7:0]  w_opcode;
  logic [7:0]  w_byte;
  assign w_shift_in = {r_shift, r_si_sync};
  assign w_opcode   = w_shift_in[7:0];

  always_comb begin
    // NOTE: default first so every path assigns w_byte and no latch is inferred.
    w_byte = STATUS_BYTE;
    case (r_src)
      SRC_MEM: w_byte = r_rd_data;
      SRC_ID:  w_byte = id_byte(JEDEC_ID, r_addr);
      default: w_byte = STATUS_BYTE;
    endcase
  end

  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_src     <= SRC_MEM;
      r_bit_cnt <= 5'd0;
      r_shift   <= 23'd0;
      r_addr    <= 24'd0;
      r_tx      <= 8'd0;
      r_so      <= 1'b0;
      r_cmd_err <= 1'b0;
    end else begin
      r_cmd_err <= 1'b0;
      if (w_cs_rise) begin
        r_state   <= IDLE;
        r_so      <= 1'b0;
        r_bit_cnt <= 5'd0;
      end else begin
        case (r_state)
          IDLE: if (w_cs_fall && w_cs_armed) begin
            r_state   <= CMD;
            r_bit_cnt <= 5'd0;
            r_shift   <= 23'd0;
          end
          CMD: if (w_sck_rise) begin
            r_shift   <= w_shift_in[22:0];
            r_bit_cnt <= r_bit_cnt + 5'd1;
            if (r_bit_cnt == 5'd7) begin
              r_bit_cnt <= 5'd0;
              case (w_opcode)
                OP_READ: r_state <= ADDR;
                OP_RDID: begin r_state <= DATA; r_src <= SRC_ID;     r_addr <= 24'd0; end
                OP_RDSR: begin r_state <= DATA; r_src <= SRC_STATUS; end
                default: begin r_state <= IGNORE; r_cmd_err <= 1'b1; end
              endcase
            end
          end
          ADDR: if (w_sck_rise) begin
            r_shift   <= w_shift_in[22:0];
            r_bit_cnt <= r_bit_cnt + 5'd1;
            if (r_bit_cnt == 5'd23) begin
              r_state   <= DATA;
              r_src     <= SRC_MEM;
              r_addr    <= w_shift_in;
              r_bit_cnt <= 5'd0;
            end
          end
          DATA: if (w_sck_fall) begin
            r_bit_cnt <= {2'b00, r_bit_cnt[2:0] + 3'd1};
            if (r_bit_cnt[2:0] == 3'd0) begin
              r_so <= w_byte[7];
              r_tx <= {w_byte[6:0], 1'b0};
              if (r_src != SRC_ID || r_addr < 24'd3) r_addr <= r_addr + 24'd1;
            end else begin
              r_so <= r_tx[7];
              r_tx <= {r_tx[6:0], 1'b0};
            end
          end
          IGNORE: r_so <= 1'b0;
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign spi_so  = r_so;
  assign cmd_err = r_cmd_err;

endmodule

// File: tb/tb_spi_flash_responder.sv
// Self-checking bench for spi_flash_responder: directed scenarios plus randomized reads
// compared against a byte-level reference model of the flash.
module tb_spi_flash_responder;

  localparam int          DEPTH    = 1024;
  localparam int          AW       = $clog2(DEPTH);
  localparam logic [23:0] JEDEC_ID = 24'hEF4018;
  localparam int          HALF     = 8;

  logic          clk_50 = 1'b0;
  logic          rst = 1'b1;
  logic          spi_cs = 1'b1;
  logic          spi_sck = 1'b0;
  logic          spi_si = 1'b0;
  logic          mem_we = 1'b0;
  logic [AW-1:0] mem_waddr = '0;
  logic [7:0]    mem_wdata = 8'h00;
  logic          spi_so, busy, cmd_err;

  int n_vec = 0;
  int n_err = 0;
  int err_cycles = 0;
  logic [7:0] ref_mem [DEPTH];

  spi_flash_responder #(.DEPTH(DEPTH), .JEDEC_ID(JEDEC_ID)) dut (
    .clk_50(clk_50), .rst(rst), .spi_cs(spi_cs), .spi_sck(spi_sck), .spi_si(spi_si),
    .spi_so(spi_so), .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .busy(busy), .cmd_err(cmd_err)
  );

  always #5 clk_50 = ~clk_50;

  always @(negedge clk_50) if (cmd_err === 1'b1) err_cycles++;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  // Expected byte idx of the response to op started at addr.
  function automatic logic [7:0] model_byte(input logic [7:0] op, input logic [23:0] addr, input int idx);
    logic [23:0] a;
    logic [23:0] id;
    id = JEDEC_ID;
    case (op)
      8'h03: begin a = addr + 24'(idx); return ref_mem[int'(a) % DEPTH]; end
      8'h9F: return (idx < 3) ? id[23-8*idx -: 8] : 8'h00;
      default: return 8'h00;
    endcase
  endfunction

  task automatic mem_write(input int a, input logic [7:0] d);
    mem_we = 1'b1; mem_waddr = AW'(a); mem_wdata = d;
    @(negedge clk_50);
    mem_we = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic spi_bit(input logic b, output logic so);
    spi_si = b;
    repeat (HALF) @(negedge clk_50);
    so = spi_so;
    spi_sck = 1'b1;
    repeat (HALF) @(negedge clk_50);
    spi_sck = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(tx[i], b);
      rx[i] = b;
    end
  endtask

  task automatic cs_assert();
    spi_cs = 1'b0;
    repeat (HALF) @(negedge clk_50);
  endtask

  task automatic cs_release();
    repeat (HALF) @(negedge clk_50);
    spi_cs = 1'b1;
    repeat (4*HALF) @(negedge clk_50);
  endtask

  // Full transaction; cmd_so collects every spi_so bit seen during opcode/address.
  task automatic run_cmd(input logic [7:0] op, input logic [23:0] addr, input int nbytes,
                         output logic [7:0] rx_q[$], output logic cmd_so);
    logic [7:0] rx;
    rx_q = {};
    cs_assert();
    spi_byte(op, rx);
    cmd_so = |rx;
    if (op == 8'h03) begin
      for (int i = 2; i >= 0; i--) begin
        spi_byte(addr[8*i +: 8], rx);
        cmd_so = cmd_so | (|rx);
      end
    end
    for (int k = 0; k < nbytes; k++) begin
      spi_byte(8'($urandom), rx);
      rx_q.push_back(rx);
    end
    cs_release();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk_50);
    n_vec++; if (spi_so !== 1'b0) begin n_err++; $display("FAIL reset_so: got %b expected 0", spi_so); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_vec++; if (cmd_err !== 1'b0) begin n_err++; $display("FAIL reset_cmd_err: got %b expected 0", cmd_err); end
    rst = 1'b0;
    repeat (10) @(negedge clk_50);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_read_basic();
    logic [7:0] rx_q[$];
    logic       cmd_so;
    logic [7:0] exp [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) mem_write(i, exp[i]);
    run_cmd(8'h03, 24'h000000, 4, rx_q, cmd_so);
    n_vec++; if (cmd_so !== 1'b0) begin n_err++; $display("FAIL read_cmd_so: got %b expected 0", cmd_so); end
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (rx_q[i] !== exp[i]) begin n_err++; $display("FAIL read_basic[%0d]: got %h expected %h", i, rx_q[i], exp[i]); end
    end
  endtask

  task automatic test_read_wrap();
    logic [7:0]  rx_q[$];
    logic        cmd_so;
    logic [23:0] starts [2] = '{24'(DEPTH-1), 24'hFFFFFF};
    for (int s = 0; s < 2; s++) begin
      run_cmd(8'h03, starts[s], 2, rx_q, cmd_so);
      n_vec++; if (rx_q[0] !== ref_mem[DEPTH-1]) begin n_err++; $display("FAIL wrap_last %h: got %h expected %h", starts[s], rx_q[0], ref_mem[DEPTH-1]); end
      n_vec++; if (rx_q[1] !== ref_mem[0]) begin n_err++; $display("FAIL wrap_first %h: got %h expected %h", starts[s], rx_q[1], ref_mem[0]); end
    end
  endtask

  task automatic test_jedec();
    logic [7:0] rx_q[$];
    logic       cmd_so;
    logic [7:0] exp [4] = '{8'hEF, 8'h40, 8'h18, 8'h00};
    run_cmd(8'h9F, 24'h0, 4, rx_q, cmd_so);
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (rx_q[i] !== exp[i]) begin n_err++; $display("FAIL jedec[%0d]: got %h expected %h", i, rx_q[i], exp[i]); end
    end
  endtask

  task automatic test_status();
    logic [7:0] rx_q[$];
    logic       cmd_so;
    run_cmd(8'h05, 24'h0, 3, rx_q, cmd_so);
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (rx_q[i] !== 8'h00) begin n_err++; $display("FAIL status[%0d]: got %h expected 00", i, rx_q[i]); end
    end
  endtask

  task automatic test_bad_opcode();
    logic [7:0] rx_q[$];
    logic       cmd_so;
    int         e0;
    e0 = err_cycles;
    run_cmd(8'hAB, 24'h0, 2, rx_q, cmd_so);
    n_vec++; if (err_cycles - e0 !== 1) begin n_err++; $display("FAIL bad_op_err_cycles: got %0d expected 1", err_cycles - e0); end
    n_vec++; if ({rx_q[0], rx_q[1]} !== 16'h0000) begin n_err++; $display("FAIL bad_op_so: got %h%h expected 0000", rx_q[0], rx_q[1]); end
  endtask

  task automatic test_abort();
    logic [7:0] rx, part;
    logic [7:0] rx_q[$];
    logic       cmd_so, b;
    part = 8'h00;
    cs_assert();
    spi_byte(8'h03, rx);
    for (int i = 0; i < 3; i++) spi_byte(8'h00, rx);
    for (int i = 0; i < 4; i++) begin spi_bit(1'b0, b); part[7-i] = b; end
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL abort_busy: got %b expected 1", busy); end
    n_vec++; if (part[7:4] !== ref_mem[0][7:4]) begin n_err++; $display("FAIL abort_partial: got %h expected %h", part[7:4], ref_mem[0][7:4]); end
    repeat (HALF) @(negedge clk_50);
    spi_cs = 1'b1;
    repeat (6) @(negedge clk_50);
    n_vec++; if (spi_so !== 1'b0) begin n_err++; $display("FAIL abort_so: got %b expected 0", spi_so); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy_clear: got %b expected 0", busy); end
    repeat (4*HALF) @(negedge clk_50);
    run_cmd(8'h03, 24'h000002, 1, rx_q, cmd_so);
    n_vec++; if (rx_q[0] !== 8'h33) begin n_err++; $display("FAIL abort_next_read: got %h expected 33", rx_q[0]); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] rx, acc;
    logic [7:0] rx_q[$];
    logic       cmd_so;
    int         e0;
    acc = 8'h00;
    e0 = err_cycles;
    cs_assert();
    spi_byte(8'h03, rx);
    spi_byte(8'h00, rx);
    rst = 1'b1;
    repeat (3) @(negedge clk_50);
    rst = 1'b0;
    n_vec++; if (spi_so !== 1'b0) begin n_err++; $display("FAIL rstmid_so: got %b expected 0", spi_so); end
    for (int i = 0; i < 4; i++) begin spi_byte(8'h03, rx); acc = acc | rx; end
    n_vec++; if (acc !== 8'h00) begin n_err++; $display("FAIL rstmid_response: got %h expected 00", acc); end
    n_vec++; if (err_cycles !== e0) begin n_err++; $display("FAIL rstmid_cmd_err: got %0d expected %0d", err_cycles, e0); end
    cs_release();
    run_cmd(8'h03, 24'h000000, 4, rx_q, cmd_so);
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (rx_q[i] !== ref_mem[i]) begin n_err++; $display("FAIL rstmid_mem[%0d]: got %h expected %h", i, rx_q[i], ref_mem[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] rx_q[$];
    logic       cmd_so;
    run_cmd(8'h9F, 24'h0, 1, rx_q, cmd_so);
    n_vec++; if (rx_q[0] !== 8'hEF) begin n_err++; $display("FAIL b2b_id: got %h expected ef", rx_q[0]); end
    run_cmd(8'h03, 24'h000003, 1, rx_q, cmd_so);
    n_vec++; if (rx_q[0] !== 8'h44) begin n_err++; $display("FAIL b2b_read: got %h expected 44", rx_q[0]); end
  endtask

  task automatic test_random();
    logic [7:0]  ops [3] = '{8'h03, 8'h9F, 8'h05};
    logic [7:0]  rx_q[$];
    logic [7:0]  op, exp;
    logic [23:0] addr;
    logic        cmd_so;
    int          nb, e0;
    e0 = err_cycles;
    for (int t = 0; t < 12; t++) begin
      for (int w = 0; w < 2; w++) mem_write($urandom_range(DEPTH-1, 0), 8'($urandom));
      op   = ops[$urandom_range(2, 0)];
      addr = ($urandom_range(3, 0) == 0) ? 24'hFFFFFE : 24'($urandom);
      nb   = $urandom_range(4, 1);
      run_cmd(op, addr, nb, rx_q, cmd_so);
      n_vec++; if (cmd_so !== 1'b0) begin n_err++; $display("FAIL rand%0d_cmd_so: got %b expected 0", t, cmd_so); end
      for (int k = 0; k < nb; k++) begin
        exp = model_byte(op, addr, k);
        n_vec++;
        if (rx_q[k] !== exp) begin n_err++; $display("FAIL rand%0d op %h addr %h byte %0d: got %h expected %h", t, op, addr, k, rx_q[k], exp); end
      end
    end
    n_vec++; if (err_cycles !== e0) begin n_err++; $display("FAIL rand_cmd_err: got %0d expected %0d", err_cycles, e0); end
  endtask

  initial begin
    test_reset();
    for (int a = 0; a < DEPTH; a++) mem_write(a, 8'($urandom));
    repeat (4) @(negedge clk_50);
    test_read_basic();
    test_read_wrap();
    test_jedec();
    test_status();
    test_bad_opcode();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
